// File: rtl/traffic_phase_timer.sv
// Traffic light phase timer.
// Tracks the controller's light code, counts whole seconds through each red/green
// (long) or red_amber/amber (short) phase, and pulses timer_30s / timer_3s one clock
// after the phase expires. Also synchronises the pedestrian button and produces one
// pulse per debounced press.
// Optional feature: define TRAFFIC_BTN_DEBOUNCE_EN to require the synchronised button
// level to hold steady for DEBOUNCE_CYC cycles before the debounced level follows it.
// Without the macro the synchronised level is used directly and DEBOUNCE_CYC is unused.
module traffic_phase_timer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned LONG_SEC      = 30,
  parameter int unsigned SHORT_SEC     = 3,
  parameter int unsigned DEBOUNCE_CYC  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] traff_light,
  input  logic       button_raw,
  output logic       timer_30s,
  output logic       timer_3s,
  output logic       button,
  output logic [4:0] sec_left,
  output logic       phase_err
);

  localparam int unsigned    PreW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(TICKS_PER_SEC - 1);
  localparam logic [PreW-1:0] PreOne   = PreW'(1);
  localparam logic [4:0]     LongLoad  = 5'(LONG_SEC);
  localparam logic [4:0]     ShortLoad = 5'(SHORT_SEC);

  typedef enum logic [1:0] {StIdle, StRunLong, StRunShort, StHold} state_e;

  state_e          state_q;
  logic [2:0]      light_q;
  logic [PreW-1:0] prescaler_q;
  // Expiry is flagged on the terminal wrap and turned into the output pulse one edge later.
  logic            pend_long_q;
  logic            pend_short_q;

  logic phase_change;
  logic code_long;
  logic code_short;
  logic wrap;

  // Phase classification and prescaler wrap detection.
  always_comb begin
    phase_change = (traff_light != light_q);
    code_long    = (traff_light == 3'b001) || (traff_light == 3'b011);
    code_short   = (traff_light == 3'b101) || (traff_light == 3'b100);
    wrap         = (prescaler_q == PreMax);
  end

  // Phase FSM: a light change always wins over the running count, including on the
  // terminal wrap, so an abandoned phase never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      light_q      <= 3'b000;
      prescaler_q  <= '0;
      sec_left     <= 5'd0;
      pend_long_q  <= 1'b0;
      pend_short_q <= 1'b0;
      timer_30s    <= 1'b0;
      timer_3s     <= 1'b0;
      phase_err    <= 1'b0;
    end else begin
      light_q      <= traff_light;
      timer_30s    <= pend_long_q;
      timer_3s     <= pend_short_q;
      pend_long_q  <= 1'b0;
      pend_short_q <= 1'b0;
      if (phase_change) begin
        prescaler_q <= '0;
        if (code_long) begin
          sec_left  <= LongLoad;
          state_q   <= StRunLong;
          phase_err <= 1'b0;
        end else if (code_short) begin
          sec_left  <= ShortLoad;
          state_q   <= StRunShort;
          phase_err <= 1'b0;
        end else begin
          sec_left  <= 5'd0;
          state_q   <= StIdle;
          phase_err <= 1'b1;
        end
      end else begin
        case (state_q)
          StRunLong, StRunShort: begin
            if (wrap) begin
              prescaler_q <= '0;
              sec_left    <= sec_left - 5'd1;
              if (sec_left == 5'd1) begin
                state_q      <= StHold;
                pend_long_q  <= (state_q == StRunLong);
                pend_short_q <= (state_q == StRunShort);
              end
            end else begin
              prescaler_q <= prescaler_q + PreOne;
            end
          end
          default: begin
            // Idle and hold wait for the next phase change.
          end
        endcase
      end
    end
  end

  logic sync1_q;
  logic sync2_q;
  logic deb_prev_q;
  logic deb_level;

`ifdef TRAFFIC_BTN_DEBOUNCE_EN
  localparam int unsigned     CntW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            deb_q;
  logic [CntW-1:0] cnt_q;

  // Debounce: follow the synchronised level only after DEBOUNCE_CYC consecutive
  // cycles of disagreement with the current debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      deb_q <= sync2_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  assign deb_level = deb_q;
`else
  assign deb_level = sync2_q;
`endif

  // Button synchroniser and rising-edge pulse, independent of the phase FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_prev_q <= 1'b0;
      button     <= 1'b0;
    end else begin
      sync1_q    <= button_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_level;
      button     <= deb_level & ~deb_prev_q;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer with a small time base.
// Expected pulse cycles are queued when stimulus is applied and retired by a monitor.
module tb_traffic_phase_timer;

  localparam int unsigned Tps = 4;
  localparam int unsigned Ls  = 30;
  localparam int unsigned Ss  = 3;
  localparam int unsigned Dc  = 8;
`ifdef TRAFFIC_BTN_DEBOUNCE_EN
  localparam int unsigned BtnLat = 2 + Dc + 1;
`else
  localparam int unsigned BtnLat = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] traff_light = 3'b001;
  logic       button_raw = 1'b0;
  logic       timer_30s;
  logic       timer_3s;
  logic       button;
  logic [4:0] sec_left;
  logic       phase_err;

  traffic_phase_timer #(
    .TICKS_PER_SEC(Tps),
    .LONG_SEC     (Ls),
    .SHORT_SEC    (Ss),
    .DEBOUNCE_CYC (Dc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .traff_light(traff_light),
    .button_raw (button_raw),
    .timer_30s  (timer_30s),
    .timer_3s   (timer_3s),
    .button     (button),
    .sec_left   (sec_left),
    .phase_err  (phase_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_30_q[$];
  int unsigned exp_3_q[$];
  int unsigned exp_btn_q[$];

  // Monitor: every observed pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    int unsigned e;
    if (timer_30s || timer_3s) begin
      n_checks++;
      if (timer_30s && timer_3s) $display("FAIL timers_exclusive: both high at cycle %0d", cyc);
      else n_pass++;
    end
    if (timer_30s) begin
      n_checks++;
      if (exp_30_q.size() == 0) $display("FAIL timer_30s_unexpected: pulse at %0d, none due", cyc);
      else begin
        e = exp_30_q.pop_front();
        if (cyc !== e) $display("FAIL timer_30s_time: pulse at %0d, want %0d", cyc, e);
        else n_pass++;
      end
    end
    if (timer_3s) begin
      n_checks++;
      if (exp_3_q.size() == 0) $display("FAIL timer_3s_unexpected: pulse at %0d, none due", cyc);
      else begin
        e = exp_3_q.pop_front();
        if (cyc !== e) $display("FAIL timer_3s_time: pulse at %0d, want %0d", cyc, e);
        else n_pass++;
      end
    end
    if (button) begin
      n_checks++;
      if (exp_btn_q.size() == 0) $display("FAIL button_unexpected: pulse at %0d, none due", cyc);
      else begin
        e = exp_btn_q.pop_front();
        if (cyc !== e) $display("FAIL button_time: pulse at %0d, want %0d", cyc, e);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    traff_light = 3'b001;
    reset = 1'b1;
    tick(3);
    n_checks++; if (sec_left !== 5'd0) $display("FAIL rst_sec_left: got %0d want 0", sec_left);
    else n_pass++;
    n_checks++; if (timer_30s !== 1'b0) $display("FAIL rst_timer_30s: got %b want 0", timer_30s);
    else n_pass++;
    n_checks++; if (timer_3s !== 1'b0) $display("FAIL rst_timer_3s: got %b want 0", timer_3s);
    else n_pass++;
    n_checks++; if (button !== 1'b0) $display("FAIL rst_button: got %b want 0", button);
    else n_pass++;
    n_checks++; if (phase_err !== 1'b0) $display("FAIL rst_phase_err: got %b want 0", phase_err);
    else n_pass++;
  endtask

  task automatic test_long();
    int unsigned ld;
    reset = 1'b0;
    ld = cyc + 1;
    exp_30_q.push_back(ld + Ls * Tps + 1);
    tick(1);
    n_checks++; if (sec_left !== 5'd30) $display("FAIL long_load: got %0d want 30", sec_left);
    else n_pass++;
    tick(20);
    n_checks++; if (sec_left !== 5'd25) $display("FAIL long_count: got %0d want 25", sec_left);
    else n_pass++;
    tick(140);
    n_checks++; if (sec_left !== 5'd0) $display("FAIL long_hold: got %0d want 0", sec_left);
    else n_pass++;
    n_checks++;
    if (exp_30_q.size() !== 0) $display("FAIL long_pulse_missing: %0d pending want 0",
                                        exp_30_q.size());
    else n_pass++;
  endtask

  task automatic test_short();
    int unsigned ld;
    traff_light = 3'b101;
    ld = cyc + 1;
    exp_3_q.push_back(ld + Ss * Tps + 1);
    tick(1);
    n_checks++; if (sec_left !== 5'd3) $display("FAIL short_load: got %0d want 3", sec_left);
    else n_pass++;
    tick(4);
    n_checks++; if (sec_left !== 5'd2) $display("FAIL short_count: got %0d want 2", sec_left);
    else n_pass++;
    tick(25);
    n_checks++; if (sec_left !== 5'd0) $display("FAIL short_hold: got %0d want 0", sec_left);
    else n_pass++;
    n_checks++;
    if (exp_3_q.size() !== 0) $display("FAIL short_pulse_missing: %0d pending want 0",
                                       exp_3_q.size());
    else n_pass++;
  endtask

  task automatic test_abandon();
    int unsigned ld;
    traff_light = 3'b011;
    tick(60);
    n_checks++; if (sec_left !== 5'd16) $display("FAIL abandon_mid: got %0d want 16", sec_left);
    else n_pass++;
    traff_light = 3'b100;
    ld = cyc + 1;
    exp_3_q.push_back(ld + Ss * Tps + 1);
    tick(1);
    n_checks++; if (sec_left !== 5'd3) $display("FAIL abandon_reload: got %0d want 3", sec_left);
    else n_pass++;
    tick(25);
    n_checks++;
    if (exp_3_q.size() !== 0) $display("FAIL abandon_pulse_missing: %0d pending want 0",
                                       exp_3_q.size());
    else n_pass++;
  endtask

  task automatic test_terminal_change();
    int unsigned ld;
    traff_light = 3'b101;
    tick(12);
    n_checks++; if (sec_left !== 5'd1) $display("FAIL term_last_sec: got %0d want 1", sec_left);
    else n_pass++;
    // Change lands on the terminal wrap edge: only the new phase may pulse.
    traff_light = 3'b100;
    ld = cyc + 1;
    exp_3_q.push_back(ld + Ss * Tps + 1);
    tick(1);
    n_checks++; if (sec_left !== 5'd3) $display("FAIL term_reload: got %0d want 3", sec_left);
    else n_pass++;
    tick(25);
    n_checks++;
    if (exp_3_q.size() !== 0) $display("FAIL term_pulse_missing: %0d pending want 0",
                                       exp_3_q.size());
    else n_pass++;
  endtask

  task automatic test_invalid();
    traff_light = 3'b111;
    tick(1);
    n_checks++; if (phase_err !== 1'b1) $display("FAIL inv_err_set: got %b want 1", phase_err);
    else n_pass++;
    n_checks++; if (sec_left !== 5'd0) $display("FAIL inv_sec_left: got %0d want 0", sec_left);
    else n_pass++;
    tick(10);
    n_checks++; if (phase_err !== 1'b1) $display("FAIL inv_err_hold: got %b want 1", phase_err);
    else n_pass++;
    traff_light = 3'b001;
    tick(1);
    n_checks++; if (phase_err !== 1'b0) $display("FAIL inv_err_clear: got %b want 0", phase_err);
    else n_pass++;
    n_checks++; if (sec_left !== 5'd30) $display("FAIL inv_reload: got %0d want 30", sec_left);
    else n_pass++;
  endtask

  // Continues the long run started by test_invalid.
  task automatic test_reset_mid_run();
    tick(72);
    n_checks++; if (sec_left !== 5'd12) $display("FAIL mid_sec_left: got %0d want 12", sec_left);
    else n_pass++;
    reset = 1'b1;
    tick(1);
    n_checks++; if (sec_left !== 5'd0) $display("FAIL mid_rst_sec_left: got %0d want 0", sec_left);
    else n_pass++;
    n_checks++;
    if ({timer_30s, timer_3s, button, phase_err} !== 4'b0000)
      $display("FAIL mid_rst_outputs: got %b want 0000", {timer_30s, timer_3s, button, phase_err});
    else n_pass++;
    traff_light = 3'b000;
    tick(3);
    reset = 1'b0;
    tick(60);
    n_checks++; if (sec_left !== 5'd0) $display("FAIL mid_idle: got %0d want 0", sec_left);
    else n_pass++;
  endtask

  task automatic test_button();
    int unsigned c;
    c = cyc;
    button_raw = 1'b1;
`ifndef TRAFFIC_BTN_DEBOUNCE_EN
    exp_btn_q.push_back(c + BtnLat);
`endif
    tick(3);
    button_raw = 1'b0;
    tick(30);
    n_checks++;
    if (exp_btn_q.size() !== 0) $display("FAIL btn_glitch: %0d pending want 0", exp_btn_q.size());
    else n_pass++;
    c = cyc;
    button_raw = 1'b1;
    exp_btn_q.push_back(c + BtnLat);
    tick(20);
    button_raw = 1'b0;
    tick(30);
    n_checks++;
    if (exp_btn_q.size() !== 0) $display("FAIL btn_press: %0d pending want 0", exp_btn_q.size());
    else n_pass++;
  endtask

  task automatic test_button_reset();
    int unsigned c;
    button_raw = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    c = cyc;
    exp_btn_q.push_back(c + BtnLat);
    tick(BtnLat + 20);
    button_raw = 1'b0;
    tick(30);
    n_checks++;
    if (exp_btn_q.size() !== 0) $display("FAIL btn_across_reset: %0d pending want 0",
                                         exp_btn_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_long();
    test_short();
    test_abandon();
    test_terminal_change();
    test_invalid();
    test_reset_mid_run();
    test_button();
    test_button_reset();
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, clk cycles per second.
REQ-002 SHALL have parameter LONG_SEC, default 30, red/green phase length in seconds (1..31).
REQ-003 SHALL have parameter SHORT_SEC, default 3, red_amber/amber phase length in seconds (1..31).
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 1000000, button stable-time in clk cycles.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port traff_light  input  3  current light code from controller: 001 red, 101 red_amber, 011 green, 100 amber.
REQ-008 SHALL have port button_raw  input  1  asynchronous pedestrian pushbutton level.
REQ-009 SHALL have port timer_30s  output  1  one-clk pulse, long phase expired.
REQ-010 SHALL have port timer_3s  output  1  one-clk pulse, short phase expired.
REQ-011 SHALL have port button  output  1  one-clk pulse per debounced button press.
REQ-012 SHALL have port sec_left  output  5  whole seconds remaining in current phase.
REQ-013 SHALL have port phase_err  output  1  level, traff_light holds an invalid code.

Function
REQ-014 SHALL register traff_light into light_q every clk; phase change = traff_light != light_q.
REQ-015 SHALL classify 001/011 as long, 101/100 as short, all other codes as invalid.
REQ-016 SHALL implement FSM states IDLE, RUN_LONG, RUN_SHORT, HOLD.
REQ-017 On change to long code: sec_left<=LONG_SEC, prescaler<=0, state<=RUN_LONG; short code: SHORT_SEC, RUN_SHORT; invalid code: sec_left<=0, state<=IDLE, phase_err<=1.
REQ-018 phase_err SHALL clear on the same edge that loads a valid code.
REQ-019 In RUN_*, prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; each wrap decrements sec_left.
REQ-020 On the wrap taking sec_left 1->0, state<=HOLD and timer_30s (from RUN_LONG) or timer_3s (from RUN_SHORT) SHALL be asserted on the next edge for exactly one clk.
REQ-021 First expiry pulse SHALL rise exactly LONG_SEC*TICKS_PER_SEC+1 (resp. SHORT_SEC*TICKS_PER_SEC+1) edges after the loading edge.
REQ-022 HOLD SHALL emit no further pulses and keep sec_left=0 until a phase change.
REQ-023 Phase change mid-run SHALL abandon the count with no pulse; change coinciding with terminal wrap SHALL win and suppress the pulse.
REQ-024 timer_30s and timer_3s SHALL never be high in the same cycle.
REQ-025 button_raw SHALL pass a 2-FF synchronizer; each rising edge of the debounced level SHALL produce one button pulse, independent of FSM state; button may coincide with a timer pulse.

Reset
REQ-026 While reset=1 on an edge: state IDLE, light_q=000, prescaler=0, sec_left=0, timer_30s=0, timer_3s=0, button=0, phase_err=0, synchronizer/debounce flops=0.
REQ-027 First valid code after reset release SHALL be treated as a phase change; button held across release SHALL give one pulse.
REQ-028 Reset mid-operation SHALL discard all count and pending-pulse state.

Configuration
REQ-029 Macro TRAFFIC_BTN_DEBOUNCE_EN defined: debounced level updates only after synchronized level is stable DEBOUNCE_CYC consecutive cycles; button rises 2+DEBOUNCE_CYC+1 edges after first sampled high.
REQ-030 Macro undefined: debounced level = synchronized level, no debounce counter, DEBOUNCE_CYC ignored; button rises 3 edges after first sampled high.

Verification (TICKS_PER_SEC=4, LONG_SEC=30, SHORT_SEC=3, DEBOUNCE_CYC=8)
REQ-031 Release reset with traff_light=001 -> sec_left=30, single timer_30s pulse 121 edges after load, none after while 001 held.
REQ-032 traff_light 001->101 -> sec_left=3, timer_3s pulse 13 edges later, timer_30s never high.
REQ-033 traff_light 011->100 at edge 60 of long run -> no timer_30s; timer_3s 13 edges after change.
REQ-034 traff_light=111 -> phase_err=1, sec_left=0, no pulses; then 001 -> phase_err=0, sec_left=30.
REQ-035 With macro: 3-cycle button_raw glitch -> no pulse; 20-cycle press -> one button pulse at edge 11; without macro: pulse at edge 3.
REQ-036 Reset asserted in RUN_LONG with sec_left=12 -> next edge all outputs 0, state IDLE, no pulse.
